// File: rtl/gpr_pkg.sv
// Shared widths, types and register names for the GPR bank.
// Select values 0..12 name rA..rM; 13..15 are illegal.
package gpr_pkg;

    localparam int DATA_W   = 33;
    localparam int NUM_REGS = 13;
    localparam int SEL_W    = 4;

    typedef logic [DATA_W-1:0] gpr_data_t;
    typedef logic [SEL_W-1:0]  gpr_sel_t;

    localparam gpr_sel_t R_A = 4'd0;
    localparam gpr_sel_t R_B = 4'd1;
    localparam gpr_sel_t R_C = 4'd2;
    localparam gpr_sel_t R_D = 4'd3;
    localparam gpr_sel_t R_E = 4'd4;
    localparam gpr_sel_t R_F = 4'd5;
    localparam gpr_sel_t R_G = 4'd6;
    localparam gpr_sel_t R_H = 4'd7;
    localparam gpr_sel_t R_I = 4'd8;
    localparam gpr_sel_t R_J = 4'd9;
    localparam gpr_sel_t R_K = 4'd10;
    localparam gpr_sel_t R_L = 4'd11;
    localparam gpr_sel_t R_M = 4'd12;

    function automatic logic sel_valid(gpr_sel_t sel);
        return sel <= R_M;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy scoreboard for the GPR bank plus the sticky illegal-select flag.
// A reserve beats a write to the same register; an error set beats a clear.
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic                rsv_en,
    input  logic [SEL_W-1:0]    rsv_sel,
    input  logic                err_clr,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err_sel
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;

    always_comb begin
        busy_d = busy_q;
        if (wr_en && sel_valid(wr_sel)) begin
            busy_d[wr_sel] = 1'b0;
        end
        if (rsv_en && sel_valid(rsv_sel)) begin
            busy_d[rsv_sel] = 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if ((wr_en && !sel_valid(wr_sel)) ||
            (rsv_en && !sel_valid(rsv_sel))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask = busy_q;
    assign err_sel   = err_q;

endmodule

// File: rtl/gpr_bank.sv
// Thirteen 33-bit GPRs with one write port, two read ports and a busy scoreboard.
// Optional GPR_BYPASS_EN forwards same-cycle writeback data to the read ports.
module gpr_bank
    import gpr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [SEL_W-1:0]    rsv_sel,
    input  logic [SEL_W-1:0]    rd_a_sel,
    input  logic [SEL_W-1:0]    rd_b_sel,
    output logic [DATA_W-1:0]   rd_a_data,
    output logic [DATA_W-1:0]   rd_b_data,
    output logic                rd_a_busy,
    output logic                rd_b_busy,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err_sel,
    input  logic                err_clr
);

    gpr_data_t regs_q [NUM_REGS];
    gpr_data_t regs_d [NUM_REGS];
    logic      wr_hit;

    assign wr_hit = wr_en && sel_valid(wr_sel);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_sel] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    gpr_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .rsv_en    (rsv_en),
        .rsv_sel   (rsv_sel),
        .err_clr   (err_clr),
        .busy_mask (busy_mask),
        .err_sel   (err_sel)
    );

`ifdef GPR_BYPASS_EN
    logic rsv_hit;
    assign rsv_hit = rsv_en && sel_valid(rsv_sel);
`endif

    always_comb begin
        rd_a_data = '0;
        rd_a_busy = 1'b0;
        if (sel_valid(rd_a_sel)) begin
            rd_a_data = regs_q[rd_a_sel];
            rd_a_busy = busy_mask[rd_a_sel];
        end
`ifdef GPR_BYPASS_EN
        // wr_hit implies the select is legal, so a match is too
        if (wr_hit && wr_sel == rd_a_sel) begin
            rd_a_data = wr_data;
            rd_a_busy = rsv_hit && rsv_sel == rd_a_sel;
        end
`endif
    end

    always_comb begin
        rd_b_data = '0;
        rd_b_busy = 1'b0;
        if (sel_valid(rd_b_sel)) begin
            rd_b_data = regs_q[rd_b_sel];
            rd_b_busy = busy_mask[rd_b_sel];
        end
`ifdef GPR_BYPASS_EN
        if (wr_hit && wr_sel == rd_b_sel) begin
            rd_b_data = wr_data;
            rd_b_busy = rsv_hit && rsv_sel == rd_b_sel;
        end
`endif
    end

endmodule

// File: tb/tb_gpr_bank.sv
// Directed self-checking bench for gpr_bank.
// Expected values are hand-computed; bypass cases follow GPR_BYPASS_EN.
module tb_gpr_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [32:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_sel;
    logic [3:0]  rd_a_sel;
    logic [3:0]  rd_b_sel;
    logic [32:0] rd_a_data;
    logic [32:0] rd_b_data;
    logic        rd_a_busy;
    logic        rd_b_busy;
    logic [12:0] busy_mask;
    logic        err_sel;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    gpr_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_sel   (rsv_sel),
        .rd_a_sel  (rd_a_sel),
        .rd_b_sel  (rd_b_sel),
        .rd_a_data (rd_a_data),
        .rd_b_data (rd_b_data),
        .rd_a_busy (rd_a_busy),
        .rd_b_busy (rd_b_busy),
        .busy_mask (busy_mask),
        .err_sel   (err_sel),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] got,
                         input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [32:0] big;

    initial begin
        big      = 33'h1_0000_0001;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_sel  = '0;
        rd_a_sel = '0;
        rd_b_sel = '0;
        err_clr  = 1'b0;
        #2;

        for (int i = 0; i < 16; i++) begin
            rd_a_sel = 4'(i);
            rd_b_sel = 4'(15 - i);
            #1;
            check("rst_rd_a", rd_a_data, 33'd0);
            check("rst_rd_b", rd_b_data, 33'd0);
            check("rst_busy_a", {32'd0, rd_a_busy}, 33'd0);
            check("rst_busy_b", {32'd0, rd_b_busy}, 33'd0);
        end
        check("rst_mask", {20'd0, busy_mask}, 33'd0);
        check("rst_err", {32'd0, err_sel}, 33'd0);

        tick();
        rst_n = 1'b1;
        tick();

        wr_en   = 1'b1;
        wr_data = 33'd501;
        for (int i = 0; i < 13; i++) begin
            wr_sel = 4'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            rd_a_sel = 4'(i);
            rd_b_sel = 4'(12 - i);
            #1;
            check("wr_rd_a", rd_a_data, 33'd501);
            check("wr_rd_b", rd_b_data, 33'd501);
        end
        check("wr_err", {32'd0, err_sel}, 33'd0);
        check("wr_mask", {20'd0, busy_mask}, 33'd0);

        wr_en   = 1'b1;
        wr_sel  = 4'd13;
        wr_data = 33'd502;
        tick();
        wr_en = 1'b0;
        check("ill_err", {32'd0, err_sel}, 33'd1);
        for (int i = 0; i < 13; i++) begin
            rd_a_sel = 4'(i);
            #1;
            check("ill_keep", rd_a_data, 33'd501);
        end
        rd_b_sel = 4'd13;
        #1;
        check("rd_ill_data", rd_b_data, 33'd0);
        check("rd_ill_busy", {32'd0, rd_b_busy}, 33'd0);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", {32'd0, err_sel}, 33'd0);

        rsv_en  = 1'b1;
        rsv_sel = 4'd14;
        err_clr = 1'b1;
        tick();
        rsv_en  = 1'b0;
        check("set_wins", {32'd0, err_sel}, 33'd1);
        check("ill_rsv_mask", {20'd0, busy_mask}, 33'd0);
        tick();
        err_clr = 1'b0;
        check("clr2_err", {32'd0, err_sel}, 33'd0);

        rd_a_sel = 4'd3;
        rsv_en   = 1'b1;
        rsv_sel  = 4'd3;
        tick();
        rsv_en = 1'b0;
        check("rsv_busy1", {32'd0, busy_mask[3]}, 33'd1);
        check("rsv_rd_busy1", {32'd0, rd_a_busy}, 33'd1);
        tick();
        check("rsv_busy2", {32'd0, busy_mask[3]}, 33'd1);
        wr_en   = 1'b1;
        wr_sel  = 4'd3;
        wr_data = 33'd502;
        tick();
        wr_en = 1'b0;
        check("rsv_busy3", {32'd0, busy_mask[3]}, 33'd0);
        check("rsv_rd_busy3", {32'd0, rd_a_busy}, 33'd0);
        check("rsv_data", rd_a_data, 33'd502);

        rd_a_sel = 4'd5;
        rsv_en   = 1'b1;
        rsv_sel  = 4'd5;
        wr_en    = 1'b1;
        wr_sel   = 4'd5;
        wr_data  = 33'd7;
        tick();
        rsv_en = 1'b0;
        wr_en  = 1'b0;
        check("same_data", rd_a_data, 33'd7);
        check("same_mask", {20'd0, busy_mask}, 33'h0020);
        check("same_busy", {32'd0, rd_a_busy}, 33'd1);

        rsv_en  = 1'b1;
        rsv_sel = 4'd6;
        wr_en   = 1'b1;
        wr_sel  = 4'd5;
        wr_data = 33'd8;
        tick();
        rsv_en = 1'b0;
        wr_en  = 1'b0;
        check("diff_data", rd_a_data, 33'd8);
        check("diff_mask", {20'd0, busy_mask}, 33'h0040);

        rd_a_sel = 4'd12;
        rd_b_sel = 4'd12;
        wr_en    = 1'b1;
        wr_sel   = 4'd12;
        wr_data  = big;
        #1;
`ifdef GPR_BYPASS_EN
        check("byp_same_cyc", rd_a_data, big);
        check("byp_same_b", rd_b_data, big);
`else
        check("nobyp_same_cyc", rd_a_data, 33'd501);
        check("nobyp_same_b", rd_b_data, 33'd501);
`endif
        tick();
        wr_en = 1'b0;
        check("byp_next_cyc", rd_a_data, big);
        check("byp_next_b", rd_b_data, big);

        rd_a_sel = 4'd1;
        rd_b_sel = 4'd0;
        rsv_en   = 1'b1;
        rsv_sel  = 4'd0;
        wr_en    = 1'b1;
        wr_sel   = 4'd1;
        wr_data  = 33'd99;
        tick();
        rsv_en = 1'b0;
        wr_sel = 4'd15;
        tick();
        wr_en = 1'b0;
        check("pre_rst_data", rd_a_data, 33'd99);
        check("pre_rst_busy", {32'd0, rd_b_busy}, 33'd1);
        check("pre_rst_err", {32'd0, err_sel}, 33'd1);

        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", rd_a_data, 33'd0);
        check("mid_rst_busy", {32'd0, rd_b_busy}, 33'd0);
        check("mid_rst_mask", {20'd0, busy_mask}, 33'd0);
        check("mid_rst_err", {32'd0, err_sel}, 33'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_data", rd_a_data, 33'd0);
        check("post_rst_b", rd_b_data, 33'd0);
        check("post_rst_mask", {20'd0, busy_mask}, 33'd0);
        check("post_rst_err", {32'd0, err_sel}, 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Architectural general-purpose register storage that sits directly downstream of the GPR write-select demultiplexer. It holds thirteen 33-bit registers, rA to rM, and commits one writeback per cycle addressed by a 4-bit select. It serves two combinational read ports to the operand-fetch stage. A per-register busy scoreboard lets issue logic stall on registers with pending writes.

## Interface
- Parameters:
- DATA_W, 33, register and data width
- NUM_REGS, 13, implemented registers (select 0..12 = rA..rM)
- SEL_W, 4, select width
- Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  commit wr_data to register wr_sel this cycle
- wr_sel  in  SEL_W  write target
- wr_data  in  DATA_W  writeback value
- rsv_en  in  1  mark register rsv_sel busy (instruction issued)
- rsv_sel  in  SEL_W  register to reserve
- rd_a_sel, rd_b_sel  in  SEL_W  read addresses
- rd_a_data, rd_b_data  out  DATA_W  read values
- rd_a_busy, rd_b_busy  out  1  addressed register has a pending write
- busy_mask  out  NUM_REGS  scoreboard, bit i = register i busy
- err_sel  out  1  sticky: an illegal select (13..15) was used on wr_en or rsv_en
- err_clr  in  1  clears err_sel

## Operation
- Reset (rst_n=0, asynchronous): all registers 0, busy_mask 0, err_sel 0. Reads therefore return 0 and busy 0 while reset is held.
- Write: when wr_en=1 and wr_sel<13, the register is loaded with wr_data and its busy bit is cleared at the clock edge.
- Reserve: when rsv_en=1 and rsv_sel<13, the busy bit is set at the clock edge.
- Reserve and write to the same register in one cycle: the data is written and the busy bit stays set, because the reserve wins (newer producer).
- Reserve and write to different registers: both take effect.
- Reserving an already-busy register keeps it busy; there is no counting.
- Writing a non-busy register is legal and does not raise an error.
- Illegal select (13..15) on wr_en or rsv_en: no state change, and err_sel is set at the next edge.
- err_clr: clears err_sel at the next edge. If a new illegal select arrives in the same cycle, the set wins.
- Reads are combinational from the register array. A read select of 13..15 returns data 0 and busy 0, and does not raise an error.
- Data arithmetic: none; values are stored verbatim across the full 33 bits.

## Timing
- Write-to-read latency: 1 cycle without bypass. The new value appears on rd_*_data after the edge.
- Reserve-to-busy latency: 1 cycle. busy_mask and rd_*_busy update after the edge.
- Reset deasserts synchronously to clk through the existing reset synchroniser, which is outside this block.
- Reset asserted mid-operation discards pending writes and reservations immediately.

## Configuration
- GPR_BYPASS_EN defined: a read whose select matches a valid same-cycle write returns wr_data combinationally.
  - The matching rd_*_busy reads 0, unless rsv_en targets the same register in that cycle, in which case busy reads 1.
- Not defined: same-cycle reads return the pre-edge value and busy state; there is no combinational path from wr_* to rd_*.

## Structure
- gpr_pkg holds:
  - DATA_W, NUM_REGS, SEL_W
  - typedefs gpr_data_t (logic [32:0]) and gpr_sel_t (logic [3:0])
  - localparams R_A=0 .. R_M=12
  - function sel_valid(gpr_sel_t)
- One sub-module, gpr_scoreboard, holds busy_mask with the set/clear priority and the err_sel logic.
- gpr_bank holds the register array and the read muxes, and instantiates gpr_scoreboard.

## Test plan
- Reset then read all 16 selects -> data 0, busy 0, err_sel 0.
- Write 33'd501 to each select 0..12 in turn, then read back on both ports -> 501 everywhere. Write 502 to select 13 -> no register changes, err_sel=1. Pulse err_clr -> err_sel=0.
- rsv_en to sel 3 (rD), then wr_en to sel 3 with data 502 two cycles later -> busy_mask[3]=1 for exactly two cycles, then 0, and rd_a_data=502.
- Same-cycle rsv_en and wr_en on sel 5 with data 7 -> rF=7 and busy_mask[5]=1 after the edge.
- Same-cycle write of 0x1_0000_0001 to sel 12 with rd_a_sel=12:
  - with GPR_BYPASS_EN, rd_a_data=0x1_0000_0001 in that cycle;
  - without it, the old value in that cycle and the new value next cycle.
- Reserve sel 0 and write 99 to sel 1, then assert rst_n=0 between edges -> all outputs 0 immediately, and remain 0 after release.
